// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the MEM-stage access unit: load types (also used by the
// WB extension stage), store types, and the access FSM states.
package mem_access_unit_pkg;

  localparam logic [2:0] NOREGWRITE = 3'd0;
  localparam logic [2:0] LB         = 3'd1;
  localparam logic [2:0] LH         = 3'd2;
  localparam logic [2:0] LW         = 3'd3;
  localparam logic [2:0] LBU        = 3'd4;
  localparam logic [2:0] LHU        = 3'd5;

  localparam logic [1:0] ST_NONE = 2'd0;
  localparam logic [1:0] ST_B    = 2'd1;
  localparam logic [1:0] ST_H    = 2'd2;
  localparam logic [1:0] ST_W    = 2'd3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // A load type other than NOREGWRITE takes priority over any store type.
  function automatic logic is_misaligned(input logic [2:0] ld_type,
                                         input logic [1:0] st_type,
                                         input logic [1:0] byte_off);
    logic mis;
    mis = 1'b0;
    if (ld_type != NOREGWRITE) begin
      if ((ld_type == LH || ld_type == LHU) && byte_off[0]) mis = 1'b1;
      if (ld_type == LW && byte_off != 2'b00)               mis = 1'b1;
    end else begin
      if (st_type == ST_H && byte_off[0])          mis = 1'b1;
      if (st_type == ST_W && byte_off != 2'b00)    mis = 1'b1;
    end
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_unit_store_lane_gen.sv
// Store byte-enable and lane replication: places right-aligned store data on
// every lane it may land in and enables only the addressed bytes.
module mem_access_unit_store_lane_gen
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]  store_type,
  input  logic [1:0]  byte_off,
  input  logic [31:0] store_data,
  output logic [3:0]  byte_en,
  output logic [31:0] lane_data
);

  always_comb begin
    byte_en   = 4'b0000;
    lane_data = 32'h0;
    case (store_type)
      ST_B: begin
        byte_en   = 4'b0001 << byte_off;
        lane_data = {4{store_data[7:0]}};
      end
      ST_H: begin
        byte_en   = 4'b0011 << byte_off;
        lane_data = {2{store_data[15:0]}};
      end
      ST_W: begin
        byte_en   = 4'b1111;
        lane_data = store_data;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller: one req/ack transaction at a time,
// stalls the pipe while busy. Define MEM_TIMEOUT_EN to abort stuck accesses.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int AW             = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          MemReqM,
  input  logic [2:0]    LoadTypeM,
  input  logic [1:0]    StoreTypeM,
  input  logic [AW-1:0] AddrM,
  input  logic [31:0]   StoreDataM,
  output logic          StallM,
  output logic          mem_req,
  output logic [3:0]    mem_we,
  output logic [AW-3:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ack,
  input  logic [31:0]   mem_rdata,
  output logic [31:0]   LoadWordW,
  output logic [1:0]    LoadedBytesSelectW,
  output logic [2:0]    RegWriteW,
  output logic          LoadValidW,
  output logic          MisalignW,
  output logic          BusErrW
);

  state_e        state_q, state_d;
  logic [AW-3:0] mem_addr_q, mem_addr_d;
  logic [3:0]    mem_we_q, mem_we_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [2:0]    ld_type_q, ld_type_d;
  logic [1:0]    byte_off_q, byte_off_d;
  logic [31:0]   load_word_q, load_word_d;
  logic [1:0]    bytes_sel_q, bytes_sel_d;
  logic [2:0]    reg_write_q, reg_write_d;
  logic          load_valid_q, load_valid_d;
  logic          misalign_q, misalign_d;
  logic          stall;

  logic [3:0]    lane_we;
  logic [31:0]   lane_wdata;
  logic          is_load;
  logic          is_store;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          bus_err_q, bus_err_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

  assign is_load  = (LoadTypeM != NOREGWRITE);
  assign is_store = (StoreTypeM != ST_NONE);

  mem_access_unit_store_lane_gen u_store_lane_gen (
    .store_type (StoreTypeM),
    .byte_off   (AddrM[1:0]),
    .store_data (StoreDataM),
    .byte_en    (lane_we),
    .lane_data  (lane_wdata)
  );

  always_comb begin
    state_d      = state_q;
    mem_addr_d   = mem_addr_q;
    mem_we_d     = mem_we_q;
    mem_wdata_d  = mem_wdata_q;
    ld_type_d    = ld_type_q;
    byte_off_d   = byte_off_q;
    load_word_d  = load_word_q;
    bytes_sel_d  = bytes_sel_q;
    reg_write_d  = NOREGWRITE;
    load_valid_d = 1'b0;
    misalign_d   = 1'b0;
    stall        = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d        = cnt_q;
    bus_err_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (MemReqM && (is_load || is_store)) begin
          if (is_misaligned(LoadTypeM, StoreTypeM, AddrM[1:0])) begin
            misalign_d = 1'b1;
          end else begin
            // A load alongside a store is illegal; the load wins and the store is dropped.
            state_d     = BUSY;
            mem_addr_d  = AddrM[AW-1:2];
            mem_we_d    = is_load ? 4'b0000 : lane_we;
            mem_wdata_d = is_load ? 32'h0 : lane_wdata;
            ld_type_d   = LoadTypeM;
            byte_off_d  = AddrM[1:0];
            stall       = 1'b1;
`ifdef MEM_TIMEOUT_EN
            cnt_d       = '0;
`endif
          end
        end
      end
      BUSY: begin
        if (mem_ack) begin
          state_d = IDLE;
          if (ld_type_q != NOREGWRITE) begin
            load_word_d  = mem_rdata;
            bytes_sel_d  = byte_off_q;
            reg_write_d  = ld_type_q;
            load_valid_d = 1'b1;
          end
        end else begin
`ifdef MEM_TIMEOUT_EN
          if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            state_d   = IDLE;
            bus_err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
            stall = 1'b1;
          end
`else
          stall = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      mem_addr_q   <= '0;
      mem_we_q     <= 4'b0000;
      mem_wdata_q  <= 32'h0;
      ld_type_q    <= NOREGWRITE;
      byte_off_q   <= 2'b00;
      load_word_q  <= 32'h0;
      bytes_sel_q  <= 2'b00;
      reg_write_q  <= NOREGWRITE;
      load_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      ld_type_q    <= ld_type_d;
      byte_off_q   <= byte_off_d;
      load_word_q  <= load_word_d;
      bytes_sel_q  <= bytes_sel_d;
      reg_write_q  <= reg_write_d;
      load_valid_q <= load_valid_d;
      misalign_q   <= misalign_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end
  assign BusErrW = bus_err_q;
`else
  assign BusErrW = 1'b0;
`endif

  // mem_req is decoded straight from the state flop so reset drops it at once.
  assign mem_req            = (state_q == BUSY);
  assign StallM             = stall;
  assign mem_we             = mem_we_q;
  assign mem_addr           = mem_addr_q;
  assign mem_wdata          = mem_wdata_q;
  assign LoadWordW          = load_word_q;
  assign LoadedBytesSelectW = bytes_sel_q;
  assign RegWriteW          = reg_write_q;
  assign LoadValidW         = load_valid_q;
  assign MisalignW          = misalign_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases then random
// load/store traffic against a size/alignment-based reference model.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int AW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          MemReqM;
  logic [2:0]    LoadTypeM;
  logic [1:0]    StoreTypeM;
  logic [AW-1:0] AddrM;
  logic [31:0]   StoreDataM;
  logic          StallM;
  logic          mem_req;
  logic [3:0]    mem_we;
  logic [AW-3:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_ack;
  logic [31:0]   mem_rdata;
  logic [31:0]   LoadWordW;
  logic [1:0]    LoadedBytesSelectW;
  logic [2:0]    RegWriteW;
  logic          LoadValidW;
  logic          MisalignW;
  logic          BusErrW;

  always #5 clk = ~clk;

  mem_access_unit #(.AW(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .MemReqM(MemReqM), .LoadTypeM(LoadTypeM),
    .StoreTypeM(StoreTypeM), .AddrM(AddrM), .StoreDataM(StoreDataM),
    .StallM(StallM), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .LoadWordW(LoadWordW), .LoadedBytesSelectW(LoadedBytesSelectW),
    .RegWriteW(RegWriteW), .LoadValidW(LoadValidW), .MisalignW(MisalignW),
    .BusErrW(BusErrW)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_word = 32'h0;
  logic [1:0]  exp_sel  = 2'b00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_mem_req"},   {31'b0, mem_req}, 32'd0);
    check({tag, "_mem_we"},    {28'b0, mem_we}, 32'd0);
    check({tag, "_mem_addr"},  {2'b0, mem_addr}, 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_word"},      LoadWordW, 32'd0);
    check({tag, "_sel"},       {30'b0, LoadedBytesSelectW}, 32'd0);
    check({tag, "_regwrite"},  {29'b0, RegWriteW}, {29'b0, NOREGWRITE});
    check({tag, "_lvalid"},    {31'b0, LoadValidW}, 32'd0);
    check({tag, "_misalign"},  {31'b0, MisalignW}, 32'd0);
    check({tag, "_buserr"},    {31'b0, BusErrW}, 32'd0);
    check({tag, "_stall"},     {31'b0, StallM}, 32'd0);
  endtask

  // Entered and left at a falling edge; ack arrives 'delay' cycles after the first BUSY cycle.
  task automatic run_txn(input logic [2:0] ld, input logic [1:0] st, input logic [31:0] addr,
                         input logic [31:0] data, input int delay, input logic [31:0] rdata);
    bit          is_ld;
    bit          mis;
    int          size;
    int          stalls;
    logic [3:0]  we;
    logic [31:0] wd;
    is_ld = (ld != NOREGWRITE);
    if (is_ld) size = (ld == LW) ? 4 : ((ld == LH || ld == LHU) ? 2 : 1);
    else       size = (st == ST_W) ? 4 : ((st == ST_H) ? 2 : 1);
    mis = (addr % size) != 0;
    we = 4'b0000;
    wd = 32'h0;
    if (!is_ld) begin
      case (st)
        ST_B:    begin we = 4'(1 << addr[1:0]); wd = {24'b0, data[7:0]} * 32'h01010101; end
        ST_H:    begin we = 4'(3 << addr[1:0]); wd = {16'b0, data[15:0]} * 32'h00010001; end
        default: begin we = 4'b1111;            wd = data; end
      endcase
    end

    MemReqM = 1'b1; LoadTypeM = ld; StoreTypeM = st; AddrM = addr; StoreDataM = data;
    #1 check("stall_req", {31'b0, StallM}, {31'b0, !mis});
    stalls = StallM ? 1 : 0;
    @(posedge clk); @(negedge clk);
    MemReqM = 1'b0; LoadTypeM = NOREGWRITE; StoreTypeM = ST_NONE; AddrM = $urandom;

    check("misalign", {31'b0, MisalignW}, {31'b0, mis});
    if (mis) begin
      check("mis_no_req",   {31'b0, mem_req}, 32'd0);
      check("mis_regwrite", {29'b0, RegWriteW}, {29'b0, NOREGWRITE});
      check("mis_lvalid",   {31'b0, LoadValidW}, 32'd0);
      $display("txn ld=%0d st=%0d addr=0x%08h misaligned dropped", ld, st, addr);
      return;
    end

    for (int k = 0; k <= delay; k++) begin
      check("busy_req",  {31'b0, mem_req}, 32'd1);
      check("busy_addr", {2'b0, mem_addr}, addr >> 2);
      check("busy_we",   {28'b0, mem_we}, {28'b0, we});
      if (!is_ld) check("busy_wdata", mem_wdata, wd);
      if (k == delay) begin mem_ack = 1'b1; mem_rdata = rdata; end
      #1 check("stall_busy", {31'b0, StallM}, {31'b0, k != delay});
      if (StallM) stalls++;
      @(posedge clk); @(negedge clk);
      mem_ack = 1'b0; mem_rdata = $urandom;
    end
    check("stall_count", stalls, 1 + delay);

    if (is_ld) begin exp_word = rdata; exp_sel = addr[1:0]; end
    check("w_lvalid",   {31'b0, LoadValidW}, {31'b0, is_ld});
    check("w_regwrite", {29'b0, RegWriteW}, is_ld ? {29'b0, ld} : {29'b0, NOREGWRITE});
    check("w_word",     LoadWordW, exp_word);
    check("w_sel",      {30'b0, LoadedBytesSelectW}, {30'b0, exp_sel});
    check("w_req_idle", {31'b0, mem_req}, 32'd0);
    check("w_buserr",   {31'b0, BusErrW}, 32'd0);
    @(posedge clk); @(negedge clk);
    check("after_lvalid",   {31'b0, LoadValidW}, 32'd0);
    check("after_regwrite", {29'b0, RegWriteW}, {29'b0, NOREGWRITE});
    check("after_word",     LoadWordW, exp_word);
    $display("txn ld=%0d st=%0d addr=0x%08h data=0x%08h delay=%0d rdata=0x%08h done",
             ld, st, addr, data, delay, rdata);
  endtask

  initial begin
    logic [2:0] ld_tab [6];
    logic [2:0]  ld;
    logic [1:0]  st;
    logic [31:0] addr;
    ld_tab[0] = NOREGWRITE; ld_tab[1] = LB; ld_tab[2] = LH;
    ld_tab[3] = LW;         ld_tab[4] = LBU; ld_tab[5] = LHU;

    rst = 1'b0; MemReqM = 1'b0; LoadTypeM = NOREGWRITE; StoreTypeM = ST_NONE;
    AddrM = '0; StoreDataM = '0; mem_ack = 1'b0; mem_rdata = '0;
    #1 rst = 1'b1;
    #1 check_reset_values("reset");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_txn(LW, ST_NONE, 32'h100, 32'h0, 0, 32'hDEADBEEF);
    run_txn(NOREGWRITE, ST_B, 32'h203, 32'h000000A5, 0, 32'h0);
    run_txn(LH, ST_NONE, 32'h101, 32'h0, 0, 32'h0);
    run_txn(LBU, ST_NONE, 32'h302, 32'h0, 5, 32'h12345678);
    run_txn(LW, ST_W, 32'h44, 32'hCAFEF00D, 1, 32'h0BADF00D);
    run_txn(NOREGWRITE, ST_H, 32'h2, 32'h0000BEEF, 2, 32'h0);

    // Reset in the middle of a transaction, followed by a stray ack.
    MemReqM = 1'b1; LoadTypeM = LW; StoreTypeM = ST_NONE; AddrM = 32'h400;
    @(posedge clk); @(negedge clk);
    MemReqM = 1'b0; LoadTypeM = NOREGWRITE;
    check("rst_pre_req", {31'b0, mem_req}, 32'd1);
    #2 rst = 1'b1;
    #1 check("rst_async_req", {31'b0, mem_req}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'hFFFF0000;
    @(posedge clk); @(negedge clk);
    check_reset_values("rst_mid");
    mem_ack = 1'b0; rst = 1'b0;
    exp_word = 32'h0; exp_sel = 2'b00;
    @(posedge clk); @(negedge clk);
    check("rst_after_req",    {31'b0, mem_req}, 32'd0);
    check("rst_after_lvalid", {31'b0, LoadValidW}, 32'd0);
    $display("txn reset mid-busy with late ack done");

`ifdef MEM_TIMEOUT_EN
    MemReqM = 1'b1; LoadTypeM = LW; AddrM = 32'h10;
    @(posedge clk); @(negedge clk);
    MemReqM = 1'b0; LoadTypeM = NOREGWRITE;
    for (int k = 0; k < TO; k++) begin
      check("to_busy_req", {31'b0, mem_req}, 32'd1);
      check("to_busy_err", {31'b0, BusErrW}, 32'd0);
      @(posedge clk); @(negedge clk);
    end
    check("to_req_drop", {31'b0, mem_req}, 32'd0);
    check("to_buserr",   {31'b0, BusErrW}, 32'd1);
    check("to_regwrite", {29'b0, RegWriteW}, {29'b0, NOREGWRITE});
    check("to_lvalid",   {31'b0, LoadValidW}, 32'd0);
    @(posedge clk); @(negedge clk);
    check("to_err_pulse", {31'b0, BusErrW}, 32'd0);
    $display("txn timeout abort done");
    run_txn(LW, ST_NONE, 32'h20, 32'h0, 0, 32'h600DCAFE);
`endif

    for (int i = 0; i < 40; i++) begin
      ld = ld_tab[$urandom_range(0, 5)];
      st = 2'($urandom_range(0, 3));
      if (ld == NOREGWRITE && st == ST_NONE) st = ST_W;
      addr = $urandom;
      // Bias toward aligned addresses so most requests reach memory.
      if ($urandom_range(0, 3) != 0) begin
        if (ld == LW || (ld == NOREGWRITE && st == ST_W)) addr[1:0] = 2'b00;
        else if (ld == LH || ld == LHU || (ld == NOREGWRITE && st == ST_H)) addr[0] = 1'b0;
      end
      run_txn(ld, st, addr, $urandom, $urandom_range(0, 3), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
